// File: rtl/dct_pkg.sv
// Shared widths, tag bundle and output scaling for the DCT MAC stage.
// DCT_MAC_ROUND_EN selects round-half-up scaling instead of truncation.
package dct_pkg;

  localparam int DIN_W     = 8;
  localparam int COEF_W    = 12;
  localparam int PROD_W    = DIN_W + COEF_W;
  localparam int ACC_W     = PROD_W + 3;
  localparam int OUT_W     = 12;
  localparam int SHIFT     = 11;
  localparam int BLOCK_LEN = 8;
  localparam int CNT_W     = $clog2(BLOCK_LEN);

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  function automatic logic [OUT_W-1:0] scale(
    input logic [ACC_W-1:0] sum
  );
    logic signed [ACC_W-1:0] t;
`ifdef DCT_MAC_ROUND_EN
    t = $signed(sum + ACC_W'(1 << (SHIFT - 1)));
`else
    t = $signed(sum);
`endif
    t = t >>> SHIFT;
    return t[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/dct_mac_mult.sv
// Stage 1: registered signed pixel x coefficient product with tag passthrough.
// Builds identically with or without DCT_MAC_ROUND_EN.
import dct_pkg::*;

module dct_mac_mult (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DIN_W-1:0]  din,
  input  logic [COEF_W-1:0] coef,
  output logic [PROD_W-1:0] mult_res,
  output logic              s1_valid,
  output logic              s1_first,
  output logic              s1_last
);

  tag_t              tag_q, tag_d;
  logic [PROD_W-1:0] mult_q, mult_d;
  logic [PROD_W-1:0] din_x, coef_x;

  // Sign-extend both operands so the low PROD_W bits are the signed product
  assign din_x  = {{COEF_W{din[DIN_W-1]}}, din};
  assign coef_x = {{DIN_W{coef[COEF_W-1]}}, coef};

  always_comb begin
    tag_d  = tag_q;
    mult_d = mult_q;
    if (en) begin
      tag_d = {in_valid, in_valid & in_first, in_valid & in_last};
      if (in_valid)
        mult_d = din_x * coef_x;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q  <= '0;
      mult_q <= '0;
    end else begin
      tag_q  <= tag_d;
      mult_q <= mult_d;
    end
  end

  assign mult_res = mult_q;
  assign s1_valid = tag_q.valid;
  assign s1_first = tag_q.first;
  assign s1_last  = tag_q.last;

endmodule

// File: rtl/dct_mac_accum.sv
// Accumulates eight products into one DCT coefficient and scales it out.
// DCT_MAC_ROUND_EN selects round-half-up scaling (see dct_pkg).
import dct_pkg::*;

module dct_mac_accum (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN_W-1:0]  din,
  input  logic [COEF_W-1:0] coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  dout
);

  logic              en, accept, load;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d, sum, mult_x;
  logic [OUT_W-1:0]  dout_q, dout_d;
  logic              out_valid_q, out_valid_d;
  logic [PROD_W-1:0] mult_res;
  logic              s1_valid, s1_first, s1_last;

  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;

  dct_mac_mult u_mult (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (accept),
    .in_first (cnt_q == '0),
    .in_last  (cnt_q == CNT_W'(BLOCK_LEN - 1)),
    .din      (din),
    .coef     (coef),
    .mult_res (mult_res),
    .s1_valid (s1_valid),
    .s1_first (s1_first),
    .s1_last  (s1_last)
  );

  assign mult_x = {{(ACC_W-PROD_W){mult_res[PROD_W-1]}}, mult_res};
  // A first-tagged product restarts the block with no idle cycle
  assign sum    = s1_first ? mult_x : acc_q + mult_x;
  assign load   = en & s1_valid & s1_last;

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    if (accept)
      cnt_d = cnt_q + CNT_W'(1);
    if (en & s1_valid)
      acc_d = sum;
    if (load) begin
      dout_d      = scale(sum);
      out_valid_d = 1'b1;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;

endmodule
